// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline controller: FSM states, forward-select codes
// and the destination-validity rule that depends on the current ISA mode.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  localparam logic [4:0] RV_ZERO_REG = 5'd0;
  localparam logic [4:0] ARM_PC_REG  = 5'd15;

  // x0 is hardwired zero in RISC-V and r15 is the PC in ARM; neither is a real dependency.
  function automatic logic regValid(input logic [4:0] rd, input logic armMode);
    return armMode ? (rd != ARM_PC_REG) : (rd != RV_ZERO_REG);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares two source registers against one written destination, honouring
// the ISA-dependent rule for which destinations count as real writes.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       we_i,
  input  logic       arm_i,
  output logic       hit1_o,
  output logic       hit2_o
);

  logic destLive;

  assign destLive = we_i & regValid(rd_i, arm_i);
  assign hit1_o   = destLive & (rs1_i == rd_i);
  assign hit2_o   = destLive & (rs2_i == rd_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and ISA-switch controller for a 5-stage pipeline.
// Define PIPELINE_CTRL_FORWARD_EN to enable M/W forwarding; otherwise any RAW hazard stalls.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       mode_req,
  input  logic       mode_tgt,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       arm,
  output logic       mode_ack,
  output logic       busy
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               arm_q;
  logic               tgt_q;
  logic               ack_q;

  logic inRun;
  logic hazD;
  logic stallHaz;
  logic eHit1, eHit2;

  assign inRun = (state_q == RUN);

  hazard_match uMatchE (
    .rs1_i (Rs1D), .rs2_i (Rs2D), .rd_i (RdE), .we_i (RegWriteE), .arm_i (arm_q),
    .hit1_o(eHit1), .hit2_o(eHit2)
  );

`ifdef PIPELINE_CTRL_FORWARD_EN
  logic mHitA, mHitB, wHitA, wHitB;

  hazard_match uMatchM (
    .rs1_i (Rs1E), .rs2_i (Rs2E), .rd_i (RdM), .we_i (RegWriteM), .arm_i (arm_q),
    .hit1_o(mHitA), .hit2_o(mHitB)
  );
  hazard_match uMatchW (
    .rs1_i (Rs1E), .rs2_i (Rs2E), .rd_i (RdW), .we_i (RegWriteW), .arm_i (arm_q),
    .hit1_o(wHitA), .hit2_o(wHitB)
  );

  // Only a load in execute cannot be forwarded in time.
  assign hazD = ResultSrcE0 & (eHit1 | eHit2);

  assign ForwardAE = !rst_n ? FWD_RF : mHitA ? FWD_M : wHitA ? FWD_W : FWD_RF;
  assign ForwardBE = !rst_n ? FWD_RF : mHitB ? FWD_M : wHitB ? FWD_W : FWD_RF;
`else
  logic mHit1, mHit2, wHit1, wHit2;
  logic unusedExecSrcs;

  hazard_match uMatchM (
    .rs1_i (Rs1D), .rs2_i (Rs2D), .rd_i (RdM), .we_i (RegWriteM), .arm_i (arm_q),
    .hit1_o(mHit1), .hit2_o(mHit2)
  );
  hazard_match uMatchW (
    .rs1_i (Rs1D), .rs2_i (Rs2D), .rd_i (RdW), .we_i (RegWriteW), .arm_i (arm_q),
    .hit1_o(wHit1), .hit2_o(wHit2)
  );

  // Without bypass paths, decode must wait until every in-flight producer retires.
  assign hazD = eHit1 | eHit2 | mHit1 | mHit2 | wHit1 | wHit2;

  assign ForwardAE      = FWD_RF;
  assign ForwardBE      = FWD_RF;
  assign unusedExecSrcs = ^{Rs1E, Rs2E, ResultSrcE0};
`endif

  assign stallHaz = inRun & hazD;

  assign StallF   = !rst_n | stallHaz | !inRun;
  assign StallD   = !rst_n | stallHaz;
  assign FlushD   = !rst_n | PCSrcE | !inRun;
  assign FlushE   = !rst_n | stallHaz | PCSrcE;
  assign arm      = arm_q;
  assign mode_ack = ack_q;
  assign busy     = !inRun;

  // Mode switch: freeze fetch, let E/M/W empty, flip the ISA, then acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      tgt_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (mode_req) begin
            if (mode_tgt == arm_q) begin
              ack_q <= 1'b1;
            end else begin
              tgt_q   <= mode_tgt;
              cnt_q   <= CNT_W'(DRAIN_CYCLES);
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= SWITCH;
        end
        SWITCH: begin
          arm_q   <= tgt_q;
          ack_q   <= 1'b1;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles to empty E/M/W after fetch freeze.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports Rs1D, Rs2D  in  5 each  decode-stage source registers.
REQ-005 SHALL have ports Rs1E, Rs2E, RdE  in  5 each  execute-stage sources and destination.
REQ-006 SHALL have ports RdM, RdW  in  5 each  memory/writeback destinations.
REQ-007 SHALL have ports RegWriteE, RegWriteM, RegWriteW  in  1 each  stage write enables.
REQ-008 SHALL have port ResultSrcE0  in  1  high when the execute-stage instruction is a load.
REQ-009 SHALL have port PCSrcE  in  1  taken branch/jump resolved in execute.
REQ-010 SHALL have ports mode_req, mode_tgt  in  1 each  ISA switch request pulse and target (1=ARM).
REQ-011 SHALL have ports StallF, StallD, FlushD, FlushE  out  1 each  pipeline controls.
REQ-012 SHALL have ports ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from M, 01 from W.
REQ-013 SHALL have ports arm  out 1  current ISA mode; mode_ack  out 1  one-cycle switch-complete pulse; busy  out 1  high outside RUN.

Function
REQ-014 SHALL treat a destination as valid unless it is x0 (arm=0) or r15, i.e. 5'd15 (arm=1).
REQ-015 SHALL, in RUN, assert StallF, StallD and FlushE combinationally when ResultSrcE0 & RegWriteE & RdE valid & RdE matches Rs1D or Rs2D (load-use).
REQ-016 SHALL assert FlushD and FlushE when PCSrcE=1, in any state; FlushE is the OR of all causes.
REQ-017 SHALL select ForwardAE=10 when RegWriteM & RdM valid & RdM==Rs1E, else 01 when RegWriteW & RdW valid & RdW==Rs1E, else 00; ForwardBE likewise on Rs2E; M has priority over W.
REQ-018 SHALL implement the state machine RUN -> DRAIN -> SWITCH -> RUN.
REQ-019 SHALL, in RUN, on mode_req with mode_tgt==arm, stay in RUN and pulse mode_ack the next cycle.
REQ-020 SHALL, in RUN, on mode_req with mode_tgt!=arm, latch mode_tgt, load the drain counter with DRAIN_CYCLES and enter DRAIN the next cycle.
REQ-021 SHALL, in DRAIN, hold StallF=1 and FlushD=1 and decrement the counter each cycle; move to SWITCH when the counter is 1.
REQ-022 SHALL, in SWITCH (one cycle), load arm from the latched target, hold StallF=1 and FlushD=1, pulse mode_ack the next cycle, and return to RUN.
REQ-023 SHALL ignore mode_req outside RUN; no queueing.
REQ-024 SHALL suppress the load-use stall in DRAIN and SWITCH, since decode holds only bubbles.
REQ-025 SHALL, when load-use and mode_req coincide in RUN, apply the stall that cycle and still accept the request.
REQ-026 SHALL, when PCSrcE=1 in DRAIN, keep counting; the flushes apply on top of the drain.
REQ-027 SHALL derive busy = (state != RUN).

Reset
REQ-028 SHALL, on rst_n low, immediately set state=RUN, counter=0, arm=0 (RISC-V), latched target=0 and mode_ack=0.
REQ-029 SHALL, while in reset, drive StallF, StallD, FlushD and FlushE high and ForwardAE/BE=00.
REQ-030 SHALL abandon any DRAIN or SWITCH in progress when reset is asserted, with no mode_ack.

Configuration
REQ-031 SHALL honour macro PIPELINE_CTRL_FORWARD_EN: when defined, forwarding is per REQ-017.
REQ-032 SHALL, without PIPELINE_CTRL_FORWARD_EN, tie ForwardAE/BE=00 and replace REQ-015 with a stall (StallF, StallD, FlushE) whenever Rs1D or Rs2D matches a valid, written RdE, RdM or RdW.

Structure
REQ-033 SHALL place the state enum (RUN, DRAIN, SWITCH) and the forward-select encodings (FWD_RF, FWD_M, FWD_W) in the shared package pipeline_pkg.
REQ-034 SHALL use one sub-module, hazard_match: a combinational register-compare that includes the validity rule.

Verification
REQ-035 SHALL cover forwarding: arm=0, RdM=5, RegWriteM=1, Rs1E=5, RdW=5, RegWriteW=1 -> ForwardAE=10; the same with RdM=0 -> ForwardAE=01.
REQ-036 SHALL cover load-use: ResultSrcE0=1, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; RdE=0 -> no stall.
REQ-037 SHALL cover an ISA switch: arm=0, mode_req=1, mode_tgt=1 -> busy for DRAIN_CYCLES+1 cycles, StallF=1 throughout, arm=1 and mode_ack=1 in the following cycle.
REQ-038 SHALL cover the ARM r15 rule: arm=1, RdM=15, Rs1E=15, RegWriteM=1 -> ForwardAE=00.
REQ-039 SHALL cover a branch during drain plus reset: PCSrcE=1 in cycle 2 of DRAIN -> FlushD=FlushE=1 and the drain length is unchanged; rst_n low mid-DRAIN -> RUN, arm=0, no mode_ack.
REQ-040 SHALL cover a redundant request: mode_req=1 with mode_tgt==arm -> mode_ack the next cycle, busy stays 0.
